// File: rtl/spi_rx_fifo_p_if.sv
// SPI pin and host-side bus bundle for spi_rx_fifo_p.
// The slave modport is the DUT view; the master modport is the SPI master / host view.
interface spi_rx_fifo_p_if #(
  parameter int unsigned ADDR_W = 9
);
  logic              ss;
  logic              sclk;
  logic              mosi;
  logic              miso;
  logic              miso_oe;
  logic              wr;
  logic [31:0]       data_in;
  logic              rd;
  logic [31:0]       data_out;
  logic [ADDR_W:0]   count;
  logic              full_alarm_led;
  logic              empty_alarm_led;
  logic              almost_full;
  logic              almost_empty;
  logic              overflow;
  logic              underflow;
  logic              frame_err;
  logic              clr_flags;

  modport slave (
    input  ss, sclk, mosi, wr, data_in, rd, clr_flags,
    output miso, miso_oe, data_out, count, full_alarm_led, empty_alarm_led,
           almost_full, almost_empty, overflow, underflow, frame_err
  );

  modport master (
    output ss, sclk, mosi, wr, data_in, rd, clr_flags,
    input  miso, miso_oe, data_out, count, full_alarm_led, empty_alarm_led,
           almost_full, almost_empty, overflow, underflow, frame_err
  );
endinterface

// File: rtl/spi_rx_fifo_p.sv
// Full-duplex SPI slave, oversampled in the clk domain, with a receive FIFO
// and a single-word transmit holding register.
module spi_rx_fifo_p #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned ADDR_W   = 9,
  parameter bit          CPOL     = 1'b0,
  parameter bit          CPHA     = 1'b0,
  parameter int unsigned AF_LEVEL = 2**ADDR_W - 4,
  parameter int unsigned AE_LEVEL = 4
) (
  input logic            clk,
  input logic            rst,
  spi_rx_fifo_p_if.slave bus
);

  localparam int unsigned     DEPTH    = 2**ADDR_W;
  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] AF_L     = (ADDR_W+1)'(AF_LEVEL);
  localparam logic [ADDR_W:0] AE_L     = (ADDR_W+1)'(AE_LEVEL);
  localparam logic [ADDR_W:0] CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [5:0]      LAST_BIT = 6'(DATA_W - 1);

  localparam logic [1:0] StWaitIdle = 2'd0;
  localparam logic [1:0] StIdle     = 2'd1;
  localparam logic [1:0] StActive   = 2'd2;

  logic ss_meta_q, ss_sync_q, ss_prev_q;
  logic sclk_meta_q, sclk_sync_q, sclk_prev_q;
  logic mosi_meta_q, mosi_sync_q;

  logic [1:0]        state_q, state_d;
  logic [5:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
  logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
  logic [DATA_W-1:0] tx_hold_q;
  logic              hold_msb_q, hold_msb_d;
  logic              push_req, frame_ev;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wptr_q, rptr_q;
  logic [ADDR_W:0]   count_q;
  logic [DATA_W-1:0] dout_q;
  logic              ovf_q, udf_q, ferr_q;
  logic              full, empty, push_ok, pop_ok;

  logic ss_fall, ss_rise, sclk_rise, sclk_fall, lead_e, trail_e, sample_e, shift_e;
  logic unused_data_in;

  assign unused_data_in = ^bus.data_in;

  always_ff @(posedge clk) begin
    if (rst) begin
      {ss_meta_q, ss_sync_q, ss_prev_q}       <= 3'b000;
      {sclk_meta_q, sclk_sync_q, sclk_prev_q} <= 3'b000;
      {mosi_meta_q, mosi_sync_q}              <= 2'b00;
    end else begin
      {ss_meta_q, ss_sync_q, ss_prev_q}       <= {bus.ss, ss_meta_q, ss_sync_q};
      {sclk_meta_q, sclk_sync_q, sclk_prev_q} <= {bus.sclk, sclk_meta_q, sclk_sync_q};
      {mosi_meta_q, mosi_sync_q}              <= {bus.mosi, mosi_meta_q};
    end
  end

  assign ss_fall   = ss_prev_q & ~ss_sync_q;
  assign ss_rise   = ~ss_prev_q & ss_sync_q;
  assign sclk_rise = ~sclk_prev_q & sclk_sync_q;
  assign sclk_fall = sclk_prev_q & ~sclk_sync_q;
  assign lead_e    = CPOL ? sclk_fall : sclk_rise;
  assign trail_e   = CPOL ? sclk_rise : sclk_fall;
  assign sample_e  = CPHA ? trail_e : lead_e;
  assign shift_e   = CPHA ? lead_e : trail_e;

  // hold_msb suppresses the first shift edge after a load so the freshly loaded MSB
  // is not shifted away before the master samples it.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    rx_shift_d = rx_shift_q;
    tx_shift_d = tx_shift_q;
    hold_msb_d = hold_msb_q;
    push_req   = 1'b0;
    frame_ev   = 1'b0;
    case (state_q)
      StWaitIdle: if (ss_sync_q) state_d = StIdle;
      StIdle: begin
        if (ss_fall) begin
          state_d    = StActive;
          bit_cnt_d  = '0;
          rx_shift_d = '0;
          tx_shift_d = tx_hold_q;
          hold_msb_d = CPHA;
        end
      end
      StActive: begin
        if (ss_rise) begin
          state_d   = StIdle;
          bit_cnt_d = '0;
          frame_ev  = (bit_cnt_q != '0);
        end else begin
          if (sample_e) begin
            rx_shift_d = {rx_shift_q[DATA_W-2:0], mosi_sync_q};
            if (bit_cnt_q == LAST_BIT) begin
              push_req   = 1'b1;
              bit_cnt_d  = '0;
              tx_shift_d = tx_hold_q;
              hold_msb_d = 1'b1;
            end else begin
              bit_cnt_d = bit_cnt_q + 6'd1;
            end
          end
          if (shift_e) begin
            if (hold_msb_q) hold_msb_d = 1'b0;
            else            tx_shift_d = {tx_shift_q[DATA_W-2:0], 1'b0};
          end
        end
      end
      default: state_d = StWaitIdle;
    endcase
  end

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign pop_ok  = bus.rd & ~empty;
  assign push_ok = push_req & (~full | pop_ok);

  always_ff @(posedge clk) begin
    if (!rst && push_ok) mem[wptr_q] <= rx_shift_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StWaitIdle;
      bit_cnt_q  <= '0;
      rx_shift_q <= '0;
      tx_shift_q <= '0;
      tx_hold_q  <= '0;
      hold_msb_q <= 1'b0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      dout_q     <= '0;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      rx_shift_q <= rx_shift_d;
      tx_shift_q <= tx_shift_d;
      hold_msb_q <= hold_msb_d;
      if (bus.wr) tx_hold_q <= bus.data_in[DATA_W-1:0];
      if (push_ok) wptr_q <= wptr_q + PTR_ONE;
      if (pop_ok) begin
        rptr_q <= rptr_q + PTR_ONE;
        dout_q <= mem[rptr_q];
      end
      if (push_ok && !pop_ok)      count_q <= count_q + CNT_ONE;
      else if (!push_ok && pop_ok) count_q <= count_q - CNT_ONE;
      // A new error event overrides a same-cycle clear.
      ovf_q  <= (push_req & ~push_ok) | (ovf_q & ~bus.clr_flags);
      udf_q  <= (bus.rd & empty) | (udf_q & ~bus.clr_flags);
      ferr_q <= frame_ev | (ferr_q & ~bus.clr_flags);
    end
  end

  assign bus.miso            = (state_q == StActive) ? tx_shift_q[DATA_W-1] : 1'b0;
  assign bus.miso_oe         = (state_q == StActive);
  assign bus.data_out        = 32'(dout_q);
  assign bus.count           = count_q;
  assign bus.full_alarm_led  = full;
  assign bus.empty_alarm_led = empty;
  assign bus.almost_full     = (count_q >= AF_L);
  assign bus.almost_empty    = (count_q <= AE_L);
  assign bus.overflow        = ovf_q;
  assign bus.underflow       = udf_q;
  assign bus.frame_err       = ferr_q;

endmodule

// File: tb/tb_spi_rx_fifo_p.sv
// Directed bench for spi_rx_fifo_p: a mode-0 instance for the FIFO behaviour and
// a mode-3 instance for the full-duplex MISO path.
module tb_spi_rx_fifo_p;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  spi_rx_fifo_p_if #(.ADDR_W(4)) bus0 ();
  spi_rx_fifo_p_if #(.ADDR_W(4)) bus3 ();

  spi_rx_fifo_p #(
    .DATA_W(8), .ADDR_W(4), .CPOL(1'b0), .CPHA(1'b0), .AF_LEVEL(12), .AE_LEVEL(4)
  ) u_dut0 (
    .clk(clk),
    .rst(rst),
    .bus(bus0)
  );

  spi_rx_fifo_p #(
    .DATA_W(8), .ADDR_W(4), .CPOL(1'b1), .CPHA(1'b1), .AF_LEVEL(12), .AE_LEVEL(4)
  ) u_dut3 (
    .clk(clk),
    .rst(rst),
    .bus(bus3)
  );

  // {full, empty, almost_full, almost_empty, overflow, underflow, frame_err, miso, miso_oe}
  localparam logic [8:0] RST_STATUS = 9'b0_1_0_1_000_00;

  function automatic logic [8:0] status0();
    return {bus0.full_alarm_led, bus0.empty_alarm_led, bus0.almost_full, bus0.almost_empty,
            bus0.overflow, bus0.underflow, bus0.frame_err, bus0.miso, bus0.miso_oe};
  endfunction

  function automatic logic [8:0] status3();
    return {bus3.full_alarm_led, bus3.empty_alarm_led, bus3.almost_full, bus3.almost_empty,
            bus3.overflow, bus3.underflow, bus3.frame_err, bus3.miso, bus3.miso_oe};
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One mode-0 bit; optionally pulse rd on the cycle the resulting push lands.
  task automatic m0_bit(input logic b, input bit rd_at_push);
    bus0.mosi = b;
    wait_clk(6);
    bus0.sclk = 1'b1;
    if (rd_at_push) begin
      wait_clk(2);
      bus0.rd = 1'b1;
      wait_clk(1);
      bus0.rd = 1'b0;
      wait_clk(3);
    end else begin
      wait_clk(6);
    end
    bus0.sclk = 1'b0;
  endtask

  task automatic m0_byte(input logic [7:0] b, input bit rd_at_push);
    for (int i = 7; i >= 0; i--) m0_bit(b[i], rd_at_push && (i == 0));
  endtask

  task automatic m0_start();
    bus0.ss = 1'b0;
    wait_clk(6);
  endtask

  // Optionally pulse clr_flags on the cycle the ss-rise event is processed.
  task automatic m0_end(input bit clr_at_end);
    wait_clk(6);
    bus0.ss = 1'b1;
    if (clr_at_end) begin
      wait_clk(2);
      bus0.clr_flags = 1'b1;
      wait_clk(1);
      bus0.clr_flags = 1'b0;
      wait_clk(6);
    end else begin
      wait_clk(9);
    end
  endtask

  task automatic pop0();
    bus0.rd = 1'b1;
    wait_clk(1);
    bus0.rd = 1'b0;
  endtask

  task automatic clr0();
    bus0.clr_flags = 1'b1;
    wait_clk(1);
    bus0.clr_flags = 1'b0;
  endtask

  // Mode 3: shift on falling (leading) edge, master samples MISO just before the rising edge.
  task automatic m3_byte(input logic [7:0] b, output logic [7:0] got);
    for (int i = 7; i >= 0; i--) begin
      bus3.sclk = 1'b0;
      bus3.mosi = b[i];
      wait_clk(6);
      got[i] = bus3.miso;
      bus3.sclk = 1'b1;
      wait_clk(6);
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] miso_bits;
    int         lvl;

    bus0.ss = 1'b1; bus0.sclk = 1'b0; bus0.mosi = 1'b0; bus0.wr = 1'b0;
    bus0.data_in = '0; bus0.rd = 1'b0; bus0.clr_flags = 1'b0;
    bus3.ss = 1'b1; bus3.sclk = 1'b1; bus3.mosi = 1'b0; bus3.wr = 1'b0;
    bus3.data_in = '0; bus3.rd = 1'b0; bus3.clr_flags = 1'b0;
    rst = 1'b1;
    wait_clk(3);
    rst = 1'b0;
    wait_clk(1);

    check_val("rst_status0", 32'(status0()), 32'(RST_STATUS));
    check_val("rst_count0", 32'(bus0.count), 32'd0);
    check_val("rst_data_out0", bus0.data_out, 32'd0);
    check_val("rst_status3", 32'(status3()), 32'(RST_STATUS));
    wait_clk(4);

    // Mode 0 receive of two bytes in one frame.
    m0_start();
    m0_byte(8'h1F, 1'b0);
    m0_byte(8'h25, 1'b0);
    m0_end(1'b0);
    check_val("m0_count2", 32'(bus0.count), 32'd2);
    check_val("m0_not_empty", 32'(bus0.empty_alarm_led), 32'd0);
    pop0();
    check_val("m0_pop1", bus0.data_out, 32'h1F);
    pop0();
    check_val("m0_pop2", bus0.data_out, 32'h25);
    check_val("m0_empty", 32'(bus0.empty_alarm_led), 32'd1);

    // Underflow.
    pop0();
    check_val("udf_set", 32'(bus0.underflow), 32'd1);
    check_val("udf_hold", bus0.data_out, 32'h25);
    clr0();
    check_val("udf_clr", 32'(bus0.underflow), 32'd0);

    // Overflow and wrap.
    m0_start();
    for (int k = 1; k <= 16; k++) m0_byte(8'(k), 1'b0);
    m0_end(1'b0);
    check_val("ovf_full", 32'(bus0.full_alarm_led), 32'd1);
    check_val("ovf_count16", 32'(bus0.count), 32'd16);
    check_val("ovf_not_yet", 32'(bus0.overflow), 32'd0);
    m0_start();
    m0_byte(8'd17, 1'b0);
    m0_end(1'b0);
    check_val("ovf_set", 32'(bus0.overflow), 32'd1);
    check_val("ovf_count", 32'(bus0.count), 32'd16);
    for (int i = 1; i <= 16; i++) begin
      pop0();
      lvl = 16 - i;
      check_val($sformatf("drain_%0d", i), bus0.data_out, 32'(i));
      check_val($sformatf("af_%0d", lvl), 32'(bus0.almost_full), 32'(lvl >= 12));
      check_val($sformatf("ae_%0d", lvl), 32'(bus0.almost_empty), 32'(lvl <= 4));
    end
    check_val("drain_empty", 32'(bus0.empty_alarm_led), 32'd1);
    for (int k = 0; k < 4; k++) begin
      m0_start();
      m0_byte(8'h30 + 8'(k), 1'b0);
      m0_end(1'b0);
      pop0();
      check_val($sformatf("wrap_%0d", k), bus0.data_out, 32'h30 + 32'(k));
    end
    clr0();

    // Push and pop in the same cycle while full.
    m0_start();
    for (int k = 0; k < 16; k++) m0_byte(8'h40 + 8'(k), 1'b0);
    m0_end(1'b0);
    check_val("sim_full_pre", 32'(bus0.count), 32'd16);
    m0_start();
    m0_byte(8'h50, 1'b1);
    m0_end(1'b0);
    check_val("sim_full_count", 32'(bus0.count), 32'd16);
    check_val("sim_full_noovf", 32'(bus0.overflow), 32'd0);
    check_val("sim_full_pop", bus0.data_out, 32'h40);
    for (int i = 0; i < 16; i++) begin
      pop0();
      check_val($sformatf("sim_drain_%0d", i), bus0.data_out, 32'h41 + 32'(i));
    end

    // Push and pop in the same cycle while empty.
    m0_start();
    m0_byte(8'h66, 1'b1);
    m0_end(1'b0);
    check_val("sim_empty_count", 32'(bus0.count), 32'd1);
    check_val("sim_empty_udf", 32'(bus0.underflow), 32'd1);
    check_val("sim_empty_hold", bus0.data_out, 32'h50);
    pop0();
    check_val("sim_empty_pop", bus0.data_out, 32'h66);
    clr0();

    // Partial frame.
    m0_start();
    for (int i = 0; i < 5; i++) m0_bit(1'b1, 1'b0);
    m0_end(1'b0);
    check_val("ferr_set", 32'(bus0.frame_err), 32'd1);
    check_val("ferr_count", 32'(bus0.count), 32'd0);
    clr0();
    check_val("ferr_clr", 32'(bus0.frame_err), 32'd0);
    m0_start();
    for (int i = 0; i < 5; i++) m0_bit(1'b0, 1'b0);
    m0_end(1'b1);
    check_val("ferr_wins_clr", 32'(bus0.frame_err), 32'd1);

    // Reset in the middle of a frame.
    m0_start();
    m0_byte(8'h77, 1'b0);
    m0_end(1'b0);
    check_val("mid_pre_count", 32'(bus0.count), 32'd1);
    m0_start();
    for (int i = 0; i < 4; i++) m0_bit(1'b1, 1'b0);
    rst = 1'b1;
    wait_clk(2);
    rst = 1'b0;
    wait_clk(1);
    check_val("mid_rst_status", 32'(status0()), 32'(RST_STATUS));
    check_val("mid_rst_count", 32'(bus0.count), 32'd0);
    check_val("mid_rst_data", bus0.data_out, 32'd0);
    m0_byte(8'hFF, 1'b0);
    wait_clk(6);
    check_val("mid_ignored", 32'(bus0.count), 32'd0);
    check_val("mid_oe_off", 32'(bus0.miso_oe), 32'd0);
    bus0.ss = 1'b1;
    wait_clk(6);
    m0_start();
    m0_byte(8'hC3, 1'b0);
    m0_end(1'b0);
    check_val("mid_after_count", 32'(bus0.count), 32'd1);
    pop0();
    check_val("mid_after_data", bus0.data_out, 32'hC3);

    // Mode 3 full duplex; upper data_in bits must be ignored.
    bus3.data_in = 32'hFFFF_FFA5;
    bus3.wr = 1'b1;
    wait_clk(1);
    bus3.wr = 1'b0;
    bus3.data_in = '0;
    bus3.ss = 1'b0;
    wait_clk(6);
    check_val("m3_oe_on", 32'(bus3.miso_oe), 32'd1);
    check_val("m3_first_bit", 32'(bus3.miso), 32'd1);
    m3_byte(8'h3C, miso_bits);
    wait_clk(6);
    bus3.ss = 1'b1;
    wait_clk(9);
    check_val("m3_miso_bits", 32'(miso_bits), 32'hA5);
    check_val("m3_count", 32'(bus3.count), 32'd1);
    check_val("m3_oe_off", 32'(bus3.miso_oe), 32'd0);
    check_val("m3_miso_idle", 32'(bus3.miso), 32'd0);
    check_val("m3_no_ferr", 32'(bus3.frame_err), 32'd0);
    bus3.rd = 1'b1;
    wait_clk(1);
    bus3.rd = 1'b0;
    check_val("m3_rx_data", bus3.data_out, 32'h3C);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
